// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, error codes
// and the controller state encoding.
// Optional feature macro used elsewhere in this slice: ALU_SEQ_CHAIN_EN.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_DIV0    = 2'b10
  } err_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/response channel bundle between a host and the ALU sequencer.
// slave = sequencer side, master = host side.
// With ALU_SEQ_CHAIN_EN defined the command carries an extra cmd_chain bit.
interface alu_sequencer_if #(
  parameter int DATA_W = 4,
  parameter int OPC_W  = 3
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OPC_W-1:0]  cmd_opcode;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
  logic              cmd_chain;
`endif

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [DATA_W-1:0] rsp_remainder;
  logic              rsp_zero;
  logic              rsp_overflow;
  logic [1:0]        rsp_error;

`ifdef ALU_SEQ_CHAIN_EN
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_chain, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_remainder, rsp_zero,
           rsp_overflow, rsp_error
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_chain, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_remainder, rsp_zero,
           rsp_overflow, rsp_error
  );
`else
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_remainder, rsp_zero,
           rsp_overflow, rsp_error
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_remainder, rsp_zero,
           rsp_overflow, rsp_error
  );
`endif

endinterface

// File: rtl/alu_seq_opcheck.sv
// Combinational screen for incoming commands: decides whether an opcode may
// be sent to the ALU, and flags divide-by-zero before it gets there.
module alu_seq_opcheck
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int OPC_W  = 3
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] b,
  output logic              legal,
  output err_t              err
);

  // Classify the opcode; only the four ALU operations are forwarded
  always_comb begin
    legal = 1'b0;
    err   = ERR_ILLEGAL;
    case (opcode)
      OP_ADD, OP_SUB, OP_MUL: begin
        legal = 1'b1;
        err   = ERR_NONE;
      end
      OP_DIV: begin
        if (b == '0) begin
          err = ERR_DIV0;
        end else begin
          legal = 1'b1;
          err   = ERR_NONE;
        end
      end
      default: begin
        legal = 1'b0;
        err   = ERR_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command-level controller in front of a combinational 4-bit ALU.
// Takes one command at a time, drives the ALU from registers for one
// settling cycle, captures its outputs and returns them as a response.
// Optional feature: ALU_SEQ_CHAIN_EN (operand A taken from the previous
// legal result when cmd_chain is set).
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int OPC_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  alu_sequencer_if.slave    bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OPC_W-1:0]  alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_remainder,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_t            state;
  state_t            state_nx;
  logic              legal;
  err_t              chk_err;
  logic [DATA_W-1:0] eff_a;

  logic [DATA_W-1:0] rsp_result_q;
  logic [DATA_W-1:0] rsp_remainder_q;
  logic              rsp_zero_q;
  logic              rsp_overflow_q;
  err_t              rsp_error_q;

`ifdef ALU_SEQ_CHAIN_EN
  logic [DATA_W-1:0] last_result;

  assign eff_a = bus.cmd_chain ? last_result : bus.cmd_a;
`else
  assign eff_a = bus.cmd_a;
`endif

  alu_seq_opcheck #(
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W)
  ) u_opcheck (
    .opcode (bus.cmd_opcode),
    .b      (bus.cmd_b),
    .legal  (legal),
    .err    (chk_err)
  );

  assign bus.cmd_ready     = (state == IDLE);
  assign bus.rsp_valid     = (state == RESP);
  assign busy              = (state != IDLE);
  assign bus.rsp_result    = rsp_result_q;
  assign bus.rsp_remainder = rsp_remainder_q;
  assign bus.rsp_zero      = rsp_zero_q;
  assign bus.rsp_overflow  = rsp_overflow_q;
  assign bus.rsp_error     = rsp_error_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: legal commands go through EXEC, screened ones straight to RESP
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_nx = legal ? EXEC : RESP;
        end
      end
      EXEC: begin
        state_nx = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath: ALU port registers, response capture and the completion counter
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a           <= '0;
      alu_b           <= '0;
      alu_opcode      <= '0;
      rsp_result_q    <= '0;
      rsp_remainder_q <= '0;
      rsp_zero_q      <= 1'b0;
      rsp_overflow_q  <= 1'b0;
      rsp_error_q     <= ERR_NONE;
      op_count        <= '0;
`ifdef ALU_SEQ_CHAIN_EN
      last_result     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (legal) begin
              alu_a      <= eff_a;
              alu_b      <= bus.cmd_b;
              alu_opcode <= bus.cmd_opcode;
            end else begin
              rsp_result_q    <= '0;
              rsp_remainder_q <= '0;
              rsp_zero_q      <= 1'b0;
              rsp_overflow_q  <= 1'b0;
              rsp_error_q     <= chk_err;
            end
          end
        end
        EXEC: begin
          rsp_result_q    <= alu_result;
          rsp_remainder_q <= alu_remainder;
          rsp_zero_q      <= alu_zero;
          rsp_overflow_q  <= alu_overflow;
          rsp_error_q     <= ERR_NONE;
`ifdef ALU_SEQ_CHAIN_EN
          last_result     <= alu_result;
`endif
        end
        RESP: begin
          if (bus.rsp_ready && (op_count != '1)) begin
            op_count <= op_count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a vector table of single transactions
// plus hand-written sequences for response back-pressure and mid-op reset.
// A small behavioural ALU sits on the ALU ports.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int DATA_W = 4;
  localparam int OPC_W  = 3;
  localparam int CNT_W  = 8;

  typedef struct {
    logic [2:0] opcode;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_result;
    logic [3:0] exp_rem;
    logic       exp_zero;
    logic       exp_ovf;
    logic [1:0] exp_err;
    int         exp_lat;
    logic [3:0] exp_alu_a;
    logic [3:0] exp_alu_b;
    logic [2:0] exp_alu_op;
  } vec_t;

  logic clk;
  logic reset;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OPC_W-1:0]  alu_opcode;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] alu_remainder;
  logic              alu_zero;
  logic              alu_overflow;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  int n_checks;
  int n_fail;
  int exp_count;

  vec_t vecs [9];

  alu_sequencer_if #(.DATA_W(DATA_W), .OPC_W(OPC_W)) bus ();

  alu_sequencer #(
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_opcode    (alu_opcode),
    .alu_result    (alu_result),
    .alu_remainder (alu_remainder),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .busy          (busy),
    .op_count      (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4-bit ALU: carry/borrow/high product bits raise overflow
  always_comb begin
    logic [4:0] wide;
    logic [7:0] prod;
    wide          = '0;
    prod          = '0;
    alu_result    = '0;
    alu_remainder = '0;
    alu_overflow  = 1'b0;
    case (alu_opcode)
      3'b000: begin
        wide         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = wide[3:0];
        alu_overflow = wide[4];
      end
      3'b001: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a < alu_b);
      end
      3'b010: begin
        prod         = {4'b0, alu_a} * {4'b0, alu_b};
        alu_result   = prod[3:0];
        alu_overflow = (prod[7:4] != 4'b0);
      end
      3'b111: begin
        if (alu_b != 4'b0) begin
          alu_result    = alu_a / alu_b;
          alu_remainder = alu_a % alu_b;
        end
      end
      default: begin
      end
    endcase
    alu_zero = (alu_result == 4'b0);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full transaction; called #1 after a rising edge with the DUT idle
  task automatic applyStimulus(input vec_t v);
    int cyc;
    checkOutput("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = v.opcode;
    bus.cmd_a      = v.a;
    bus.cmd_b      = v.b;
    bus.rsp_ready  = 1'b0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    cyc = 1;
    while (!bus.rsp_valid && cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("latency", 32'(cyc), 32'(v.exp_lat));
    checkOutput("rsp_result", 32'(bus.rsp_result), 32'(v.exp_result));
    checkOutput("rsp_remainder", 32'(bus.rsp_remainder), 32'(v.exp_rem));
    checkOutput("rsp_zero", 32'(bus.rsp_zero), 32'(v.exp_zero));
    checkOutput("rsp_overflow", 32'(bus.rsp_overflow), 32'(v.exp_ovf));
    checkOutput("rsp_error", 32'(bus.rsp_error), 32'(v.exp_err));
    checkOutput("alu_a", 32'(alu_a), 32'(v.exp_alu_a));
    checkOutput("alu_b", 32'(alu_b), 32'(v.exp_alu_b));
    checkOutput("alu_opcode", 32'(alu_opcode), 32'(v.exp_alu_op));
    checkOutput("busy_resp", 32'(busy), 32'd1);
    checkOutput("cmd_ready_resp", 32'(bus.cmd_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    exp_count++;
    checkOutput("rsp_valid_after", 32'(bus.rsp_valid), 32'd0);
    checkOutput("op_count", 32'(op_count), 32'(exp_count));
    checkOutput("rsp_result_held", 32'(bus.rsp_result), 32'(v.exp_result));
    checkOutput("cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_count = 0;

    //           opc     a      b      res    rem    z     o     err    lat alu_a  alu_b  alu_op
    vecs[0] = '{3'b000, 4'h3, 4'h2, 4'h5, 4'h0, 1'b0, 1'b0, 2'b00, 2, 4'h3, 4'h2, 3'b000};
    vecs[1] = '{3'b001, 4'hA, 4'h3, 4'h7, 4'h0, 1'b0, 1'b0, 2'b00, 2, 4'hA, 4'h3, 3'b001};
    vecs[2] = '{3'b111, 4'hA, 4'h3, 4'h3, 4'h1, 1'b0, 1'b0, 2'b00, 2, 4'hA, 4'h3, 3'b111};
    vecs[3] = '{3'b111, 4'h8, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b10, 1, 4'hA, 4'h3, 3'b111};
    vecs[4] = '{3'b011, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 2'b01, 1, 4'hA, 4'h3, 3'b111};
    vecs[5] = '{3'b001, 4'h3, 4'h3, 4'h0, 4'h0, 1'b1, 1'b0, 2'b00, 2, 4'h3, 4'h3, 3'b001};
    vecs[6] = '{3'b001, 4'h2, 4'h5, 4'hD, 4'h0, 1'b0, 1'b1, 2'b00, 2, 4'h2, 4'h5, 3'b001};
    vecs[7] = '{3'b000, 4'h9, 4'h7, 4'h0, 4'h0, 1'b1, 1'b1, 2'b00, 2, 4'h9, 4'h7, 3'b000};
    vecs[8] = '{3'b100, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 2'b01, 1, 4'h9, 4'h7, 3'b000};

    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_a      = '0;
    bus.cmd_b      = '0;
    bus.rsp_ready  = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
    bus.cmd_chain  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_op_count", 32'(op_count), 32'd0);
    checkOutput("reset_rsp_result", 32'(bus.rsp_result), 32'd0);
    checkOutput("reset_rsp_error", 32'(bus.rsp_error), 32'd0);
    checkOutput("reset_alu_opcode", 32'(alu_opcode), 32'd0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
    end

    // Back-pressure: mul 8*2 held for 5 cycles with a competing command
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = 3'b010;
    bus.cmd_a      = 4'h8;
    bus.cmd_b      = 4'h2;
    @(posedge clk);
    #1;
    bus.cmd_opcode = 3'b000;
    bus.cmd_a      = 4'h1;
    bus.cmd_b      = 4'h1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      checkOutput("stall_busy", 32'(busy), 32'd1);
      checkOutput("stall_result", 32'(bus.rsp_result), 32'h0);
      checkOutput("stall_zero", 32'(bus.rsp_zero), 32'd1);
      checkOutput("stall_overflow", 32'(bus.rsp_overflow), 32'd1);
      checkOutput("stall_error", 32'(bus.rsp_error), 32'd0);
      checkOutput("stall_alu_opcode", 32'(alu_opcode), 32'b010);
      checkOutput("stall_op_count", 32'(op_count), 32'(exp_count));
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    exp_count++;
    checkOutput("release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("release_op_count", 32'(op_count), 32'(exp_count));
    @(posedge clk);
    #1;
    checkOutput("ignored_cmd_idle", 32'(busy), 32'd0);
    checkOutput("ignored_cmd_alu_a", 32'(alu_a), 32'h8);

    // Reset while the add 9+6 is in EXEC drops the response
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = 3'b000;
    bus.cmd_a      = 4'h9;
    bus.cmd_b      = 4'h6;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    checkOutput("exec_busy", 32'(busy), 32'd1);
    checkOutput("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_count = 0;
    checkOutput("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("midreset_op_count", 32'(op_count), 32'd0);
    checkOutput("midreset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_rsp_result", 32'(bus.rsp_result), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("midreset_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    applyStimulus(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
